// File: rtl/lane_pipe_stream.sv
// Multi-lane registered data pipe with valid/ready flow control.
// Each beat carries NUM_CH lanes of WIDTH bits. Disabled lanes are zeroed
// when the beat is captured, and the lane enables travel with the beat.
// Pipe mode: a STAGES-deep register pipe where bubbles collapse.
// Bypass mode: a zero-latency combinational path.
// The DRAIN mode between them empties the pipe, so no beat is lost or
// reordered when the path is switched at run time.
//
// Handshake semantics (both ports): a beat moves on a rising edge exactly
// when valid and ready are both high. A producer holds valid and data
// stable until that edge. ready may depend combinationally on the
// downstream ready, but never on the producer's valid.
module lane_pipe_stream #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int STAGES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bypass_req,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*WIDTH-1:0]       in_data,
  input  logic [NUM_CH-1:0]             in_lane_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*WIDTH-1:0]       out_data,
  output logic [NUM_CH-1:0]             out_lane_en,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [1:0]                    mode
);

  localparam int DW    = NUM_CH * WIDTH;
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  localparam logic [1:0] MODE_PIPE   = 2'd0;
  localparam logic [1:0] MODE_DRAIN  = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  logic [STAGES-1:0] valid_q;
  logic [DW-1:0]     data_q [STAGES];
  logic [NUM_CH-1:0] lane_q [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_next;
  logic [1:0]        mode_q;
  logic [1:0]        mode_next;

  logic [STAGES-1:0] stage_rdy;
  logic [DW-1:0]     masked_in;
  logic              pipe_in_xfer;
  logic              pipe_out_xfer;

  // Zero the disabled lanes of the incoming beat.
  always_comb begin
    masked_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_lane_en[i]) masked_in[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // A stage can take new data when it is empty or its content moves on.
  // The chain is computed from the output back to the input.
  always_comb begin
    logic r;
    stage_rdy = '0;
    r = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      stage_rdy[k] = !valid_q[k] | r;
      r = stage_rdy[k];
    end
  end

  // Port muxing: in bypass mode the ports are wired through; otherwise the
  // last stage drives the output.
  always_comb begin
    out_valid   = valid_q[LAST];
    out_data    = data_q[LAST];
    out_lane_en = lane_q[LAST];
    in_ready    = (mode_q == MODE_PIPE) & stage_rdy[0] & !bypass_req;
    if (mode_q == MODE_BYPASS) begin
      // Once the bypass request is dropped, this cycle passes no beat.
      // The pipe takes over on the next edge.
      out_valid   = bypass_req & in_valid;
      out_data    = masked_in;
      out_lane_en = in_lane_en;
      in_ready    = bypass_req & out_ready;
    end
  end

  assign pipe_in_xfer  = in_valid & in_ready & (mode_q == MODE_PIPE);
  assign pipe_out_xfer = valid_q[LAST] & out_ready & (mode_q != MODE_BYPASS);
  assign occ_next      = occ_q + OCC_W'(pipe_in_xfer) - OCC_W'(pipe_out_xfer);

  // Mode selection. It uses the occupancy after this edge's transfers, so
  // the last drained beat and the switch to bypass share one edge.
  always_comb begin
    mode_next = mode_q;
    case (mode_q)
      MODE_PIPE: begin
        if (bypass_req) mode_next = (occ_next == '0) ? MODE_BYPASS : MODE_DRAIN;
      end
      MODE_DRAIN: begin
        if (!bypass_req)          mode_next = MODE_PIPE;
        else if (occ_next == '0)  mode_next = MODE_BYPASS;
      end
      MODE_BYPASS: begin
        if (!bypass_req) mode_next = MODE_PIPE;
      end
      default: mode_next = MODE_PIPE;
    endcase
  end

  // Pipe stages: each stage shifts forward whenever it is ready.
  // Stage 0 captures the masked input beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        lane_q[k] <= '0;
      end
    end else begin
      if (stage_rdy[0]) begin
        valid_q[0] <= pipe_in_xfer;
        if (pipe_in_xfer) begin
          data_q[0] <= masked_in;
          lane_q[0] <= in_lane_en;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            lane_q[k] <= lane_q[k-1];
          end
        end
      end
    end
  end

  // Occupancy counter and registered mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q  <= '0;
      mode_q <= MODE_PIPE;
    end else begin
      occ_q  <= occ_next;
      mode_q <= mode_next;
    end
  end

  assign occupancy = occ_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_lane_pipe_stream.sv
// Testbench for lane_pipe_stream (WIDTH=8, NUM_CH=4, STAGES=3).
// The driver pushes expected beats into a queue.
// A negedge monitor pops the queue and compares on every output transfer.
module tb_lane_pipe_stream;

  localparam int W = 36;  // {lane_en[3:0], data[31:0]}

  logic        clk;
  logic        reset;
  logic        bypass_req;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_lane_en;
  logic [1:0]  occupancy;
  logic [1:0]  mode;

  logic [W-1:0] exp_q[$];
  int           out_edges[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           acc_edge = 0;

  lane_pipe_stream #(.WIDTH(8), .NUM_CH(4), .STAGES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bypass_req (bypass_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_lane_en (in_lane_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane_en(out_lane_en),
    .occupancy  (occupancy),
    .mode       (mode)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: on each output transfer, pop and compare.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      logic [W-1:0] e;
      out_edges.push_back(cyc + 1);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected none", {out_lane_en, out_data});
      end else begin
        e = exp_q.pop_front();
        if ({out_lane_en, out_data} !== e) begin
          n_err++;
          $display("FAIL out_beat: got %0h expected %0h", {out_lane_en, out_data}, e);
        end
      end
    end
  end

  function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = en[i] ? d[i*8 +: 8] : 8'h00;
    return m;
  endfunction

  // Present a beat and wait for it to be accepted. in_valid stays high
  // on return. acc_edge holds the number of the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] en);
    bit ok = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_lane_en = en;
    exp_q.push_back({en, mask(d, en)});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      void'(exp_q.pop_back());
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    acc_edge = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 60 && out_edges.size() < n; i++) @(posedge clk);
    #1;
    if (out_edges.size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL out_timeout: got %0d beats expected %0d", out_edges.size(), n);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; bypass_req = 1'b0; in_valid = 1'b0; in_data = '0;
    in_lane_en = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_mode", mode, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: stream 0x01..0x08 on lane 0, latency 3, no gaps
    out_ready = 1'b1;
    out_edges.delete();
    begin
      int first_acc;
      for (int i = 1; i <= 8; i++) begin
        send_beat(32'(i), 4'b0001);
        if (i == 1) first_acc = acc_edge;
      end
      in_valid = 1'b0;
      wait_outs(8);
      if (out_edges.size() >= 8) begin
        check("t1_latency", out_edges[0] - first_acc, 3);
        check("t1_no_gaps", out_edges[7] - out_edges[0], 7);
      end
    end
    wait_empty();

    // 2: fill with out_ready low, then drain in order
    out_ready = 1'b0;
    send_beat(32'h0000_00A1, 4'b1111);
    send_beat(32'h0000_00A2, 4'b1111);
    send_beat(32'h0000_00A3, 4'b1111);
    in_data = 32'h0000_00A4; in_lane_en = 4'b1111;  // in_valid still high
    @(negedge clk);
    check("t2_full_in_ready", in_ready, 0);
    check("t2_full_occ", occupancy, 3);
    check("t2_full_out_data", out_data, 32'h0000_00A1);
    @(negedge clk);
    check("t2_hold_out_data", out_data, 32'h0000_00A1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_occ_%0d", i), occupancy, 3 - i);
      @(posedge clk); #1;
    end
    wait_empty();

    // 3: lane masking
    send_beat(32'hDDCC_BBAA, 4'b0101);
    in_valid = 1'b0;
    wait_empty();

    // 4: drain before bypass, then zero-latency bypass
    out_ready = 1'b0;
    send_beat(32'h0000_00B1, 4'b0011);
    send_beat(32'h0000_00B2, 4'b0011);
    in_valid = 1'b0;
    @(posedge clk); #1;
    bypass_req = 1'b1;
    @(negedge clk);
    check("t4_req_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_drain_mode", mode, 1);
    check("t4_drain_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mode == 2'd2) begin seen = 1; break; end
      end
      check("t4_bypass_mode", mode, 2);
      check("t4_drained_first", exp_q.size(), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h1122_3344; in_lane_en = 4'b1111;
    exp_q.push_back({4'b1111, 32'h1122_3344});
    @(negedge clk);
    check("t4_byp_out_valid", out_valid, 1);
    check("t4_byp_out_data", out_data, 32'h1122_3344);
    check("t4_byp_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 5: leave bypass; in_ready low during the switch, then latency 3
    bypass_req = 1'b0;
    @(negedge clk);
    check("t5_switch_mode", mode, 2);
    check("t5_switch_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_pipe_mode", mode, 0);
    @(posedge clk); #1;
    out_edges.delete();
    send_beat(32'h0000_0077, 4'b0001);
    in_valid = 1'b0;
    wait_outs(1);
    if (out_edges.size() >= 1) check("t5_latency", out_edges[0] - acc_edge, 3);
    wait_empty();

    // 6: asynchronous reset with beats in flight
    out_ready = 1'b0;
    send_beat(32'h0000_00C1, 4'b1111);
    send_beat(32'h0000_00C2, 4'b1111);
    send_beat(32'h0000_00C3, 4'b1111);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_mode", mode, 0);
    exp_q.delete();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    out_edges.delete();
    send_beat(32'h0000_005A, 4'b0001);
    in_valid = 1'b0;
    wait_outs(1);
    if (out_edges.size() >= 1) check("t6_latency", out_edges[0] - acc_edge, 3);
    wait_empty();
    check("t6_occ_end", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
